// File: rtl/detector_sentido_if.sv
// Gate sensor / occupancy pulse bundle for detector_sentido.
// master: the side that owns the photo barriers and consumes the pulses.
// slave : the direction detector itself.
interface detector_sentido_if;
    logic       sensor_a;   // outer beam, 1 = blocked
    logic       sensor_b;   // inner beam, 1 = blocked
    logic       entrada;    // one-cycle pulse, completed entry
    logic       salida;     // one-cycle pulse, completed exit
    logic       error;      // one-cycle pulse, illegal sequence / timeout
    logic [2:0] estado;     // current FSM state code

    modport master (output sensor_a, sensor_b,
                    input  entrada, salida, error, estado);
    modport slave  (input  sensor_a, sensor_b,
                    output entrada, salida, error, estado);
endinterface

// File: rtl/detector_sentido.sv
// detector_sentido: car-park gate direction detector.
// Two raw photo barriers (A outer, B inner) are synchronised, debounced and
// fed to an FSM that emits one entrada/salida pulse per complete legal passage.
// Optional macro SENSOR_TIMEOUT_EN adds a mid-passage timeout that aborts a
// stalled passage into ESPERA with an error pulse.
module detector_sentido #(
    parameter int DEB_CYCLES     = 4,     // 1..255
    parameter int TIMEOUT_CYCLES = 1000   // 2..65535, timeout build only
) (
    input  logic               clk,
    input  logic               rst_n,
    detector_sentido_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IN1    = 3'd1,
        IN2    = 3'd2,
        IN3    = 3'd3,
        OUT1   = 3'd4,
        OUT2   = 3'd5,
        OUT3   = 3'd6,
        ESPERA = 3'd7
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [1:0]      r_sync_a, r_sync_b;
    logic [1:0]      w_s;          // [0] = A, [1] = B after synchronisation
    logic [1:0]      r_f;          // filtered levels, [0] = a_f, [1] = b_f
    logic [1:0][7:0] r_cnt;        // per-sensor debounce counters
    logic [1:0]      w_ab;         // FSM input pair {a_f, b_f}
    state_t          r_state;
    logic            r_ent, r_sal, r_err;

`ifdef SENSOR_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_tmo;
    logic        w_in_pass;
    assign w_in_pass = (r_state != IDLE) && (r_state != ESPERA);
`endif

    assign w_s  = {r_sync_b[1], r_sync_a[1]};
    assign w_ab = {r_f[0], r_f[1]};

    // Two-flop synchronisers for the asynchronous barrier inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[0], bus.sensor_a};
            r_sync_b <= {r_sync_b[0], bus.sensor_b};
        end
    end

    // Debounce: a level must disagree for DEB_CYCLES consecutive edges to be taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f   <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_s[i] != r_f[i]) begin
                    if (r_cnt[i] == DEB_LAST) begin
                        r_f[i]   <= w_s[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 8'd1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Passage FSM with registered pulses; table is mirrored for the exit path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ent   <= 1'b0;
            r_sal   <= 1'b0;
            r_err   <= 1'b0;
`ifdef SENSOR_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            r_ent <= 1'b0;
            r_sal <= 1'b0;
            r_err <= 1'b0;
`ifdef SENSOR_TIMEOUT_EN
            // Runs only mid-passage; IDLE always precedes entry so it starts at 0.
            r_tmo <= w_in_pass ? r_tmo + 16'd1 : 16'd0;
            if (w_in_pass && r_tmo == TMO_LAST) begin
                r_err   <= 1'b1;
                r_state <= ESPERA;
            end else
`endif
            begin
                case (r_state)
                    IDLE: case (w_ab)
                        2'b10: r_state <= IN1;
                        2'b01: r_state <= OUT1;
                        2'b11: begin r_state <= ESPERA; r_err <= 1'b1; end
                        default: ;
                    endcase
                    IN1: case (w_ab)
                        2'b11: r_state <= IN2;
                        2'b00: r_state <= IDLE;
                        2'b01: begin r_state <= ESPERA; r_err <= 1'b1; end
                        default: ;
                    endcase
                    IN2: case (w_ab)
                        2'b01: r_state <= IN3;
                        2'b10: r_state <= IN1;
                        2'b00: begin r_state <= IDLE; r_err <= 1'b1; end
                        default: ;
                    endcase
                    IN3: case (w_ab)
                        2'b00: begin r_state <= IDLE; r_ent <= 1'b1; end
                        2'b11: r_state <= IN2;
                        2'b10: begin r_state <= ESPERA; r_err <= 1'b1; end
                        default: ;
                    endcase
                    OUT1: case (w_ab)
                        2'b11: r_state <= OUT2;
                        2'b00: r_state <= IDLE;
                        2'b10: begin r_state <= ESPERA; r_err <= 1'b1; end
                        default: ;
                    endcase
                    OUT2: case (w_ab)
                        2'b10: r_state <= OUT3;
                        2'b01: r_state <= OUT1;
                        2'b00: begin r_state <= IDLE; r_err <= 1'b1; end
                        default: ;
                    endcase
                    OUT3: case (w_ab)
                        2'b00: begin r_state <= IDLE; r_sal <= 1'b1; end
                        2'b11: r_state <= OUT2;
                        2'b01: begin r_state <= ESPERA; r_err <= 1'b1; end
                        default: ;
                    endcase
                    default: if (w_ab == 2'b00) r_state <= IDLE;   // ESPERA
                endcase
            end
        end
    end

    assign bus.entrada = r_ent;
    assign bus.salida  = r_sal;
    assign bus.error   = r_err;
    assign bus.estado  = r_state;

endmodule

// File: tb/tb_detector_sentido.sv
// Scoreboard bench for detector_sentido: a path-position reference model
// pushes expected pulses; a negedge monitor pops and compares them.
module tb_detector_sentido;
    localparam int DEB = 4;
    localparam int TO  = 50;
`ifdef SENSOR_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    detector_sentido_if bus();
    detector_sentido #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct { int kind; int cyc; } ev_t;   // kind: 1 entrada, 2 salida, 3 error
    ev_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model state
    int   mode = 0;     // 0 idle, 1 entry path, 2 exit path, 3 waiting for clear
    int   pos  = 0;     // position along the current path (1..3)
    int   t0   = 0;     // edge at which the passage started
    bit   fa = 0, fb = 0;
    bit   ha [DEB+2];
    bit   hb [DEB+2];
    int   exp_st = 0;

    // Legal sequence of {A,B} pairs for one passage; exit path is A/B swapped.
    function automatic logic [1:0] path(int dir, int p);
        logic [1:0] e [5];
        logic [1:0] v;
        e = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        v = e[p];
        return (dir == 1) ? v : {v[0], v[1]};
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model, evaluated at every clock edge
    always @(posedge clk) begin
        logic [1:0] cur;
        int kind;
        bit mis_a, mis_b;
        cyc++;
        if (!rst_n) begin
            mode = 0; pos = 0; fa = 0; fb = 0;
            for (int i = 0; i < DEB+2; i++) begin ha[i] = 0; hb[i] = 0; end
        end else begin
            cur  = {fa, fb};
            kind = 0;
            if (mode == 0) begin
                if (cur == 2'b10)      begin mode = 1; pos = 1; t0 = cyc; end
                else if (cur == 2'b01) begin mode = 2; pos = 1; t0 = cyc; end
                else if (cur == 2'b11) begin mode = 3; kind = 3; end
            end else if (mode == 3) begin
                if (cur == 2'b00) mode = 0;
            end else if (TMO_ON && (cyc - t0 == TO)) begin
                kind = 3; mode = 3;
            end else if (cur == path(mode, pos + 1)) begin
                pos++;
                if (pos == 4) begin kind = mode; mode = 0; end
            end else if (cur == path(mode, pos - 1)) begin
                pos--;
                if (pos == 0) mode = 0;
            end else if (cur != path(mode, pos)) begin
                kind = 3;
                mode = (cur == 2'b00) ? 0 : 3;
            end
            if (kind != 0) exp_q.push_back('{kind, cyc});
            // filtered level flips once DEB synchronised samples all disagree
            for (int i = DEB+1; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
            ha[0] = bus.sensor_a;
            hb[0] = bus.sensor_b;
            mis_a = 1; mis_b = 1;
            for (int i = 0; i < DEB; i++) begin
                if (ha[2+i] == fa) mis_a = 0;
                if (hb[2+i] == fb) mis_b = 0;
            end
            if (mis_a) fa = ~fa;
            if (mis_b) fb = ~fb;
        end
        exp_st = (mode == 0) ? 0 : (mode == 3) ? 7 : (mode == 1) ? pos : pos + 3;
    end

    // Monitor: compare state and any presented pulse against the scoreboard
    always @(negedge clk) begin
        int n, k;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_pulse_kind", 0, exp_q[0].kind);
                void'(exp_q.pop_front());
            end
            chk("estado", int'(bus.estado), exp_st);
            n = int'(bus.entrada) + int'(bus.salida) + int'(bus.error);
            if (n > 1) chk("pulses_exclusive", n, 1);
            if (n >= 1) begin
                k = bus.entrada ? 1 : bus.salida ? 2 : 3;
                if (exp_q.size() == 0) chk("unexpected_pulse_kind", k, 0);
                else begin
                    chk("pulse_kind", k, exp_q[0].kind);
                    chk("pulse_cycle", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(bit a, bit b, int hold);
        @(negedge clk);
        bus.sensor_a = a;
        bus.sensor_b = b;
        repeat (hold - 1) @(negedge clk);
    endtask

    initial begin
        bit seen;
        bus.sensor_a = 1'b0;
        bus.sensor_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_estado", int'(bus.estado), 0);
        chk("reset_pulses", int'(bus.entrada) + int'(bus.salida) + int'(bus.error), 0);
        rst_n = 1'b1;
        drive(0, 0, 10);

        // entry, exit
        drive(1, 0, 20); drive(1, 1, 20); drive(0, 1, 20); drive(0, 0, 30);
        drive(0, 1, 20); drive(1, 1, 20); drive(1, 0, 20); drive(0, 0, 30);
        // glitches: 3 cycles rejected, 4 cycles accepted then reversed
        drive(1, 0, 3);  drive(0, 0, 20);
        drive(1, 0, 4);  drive(0, 0, 20);
        // reversal, simultaneous rise
        drive(1, 0, 20); drive(1, 1, 20); drive(1, 0, 20); drive(0, 0, 20);
        drive(1, 1, 20); drive(0, 0, 20);
        // timeout scenario (held passage)
        drive(1, 0, 100); drive(0, 0, 30);

        // reset while in IN2
        drive(1, 0, 20);
        drive(1, 1, 1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.estado == 3'd2) seen = 1;
        end
        chk("reached_IN2", int'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_estado", int'(bus.estado), 0);
        chk("async_reset_pulses", int'(bus.entrada) + int'(bus.salida) + int'(bus.error), 0);
        bus.sensor_a = 1'b0;
        bus.sensor_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 30);

        // randomized sensor activity, mostly long holds with some glitches
        for (int it = 0; it < 250; it++) begin
            int hold;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 30);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hold);
        end
        drive(0, 0, 40);

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
